// File: rtl/mac_pkg.sv
// Shared definitions for the product accumulator: sequencing states and the
// default datapath widths used by the MAC back end.
package mac_pkg;

    localparam int DEF_PROD_W = 32;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_ACC_W  = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/beat_counter.sv
// Loadable down-counter tracking the product beats still owed in a run,
// with a terminal (one beat left) flag and a zero-length flag on the load value.
module beat_counter
    import mac_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             dec,
    output logic             last,
    output logic             zero_len
);

    logic [CNT_W-1:0] remaining;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of the order the simulator runs processes.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= len;
        end else if (dec && (remaining != '0)) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign last     = (remaining == CNT_W'(1));
    assign zero_len = (len == '0);

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of unsigned product beats into a wide accumulator
// and presents the result on a valid/ready output with a sticky overflow flag.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              busy,
    output logic              overflow
);

    state_t state;
    state_t state_next;

    logic             start_accept;
    logic             beat;
    logic             last;
    logic             zero_len;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign in_ready     = (state == ACCUM);
    assign out_valid    = (state == DONE);
    assign busy         = (state != IDLE);
    assign start_accept = (state == IDLE) && start;
    assign beat         = in_valid && in_ready;

    // One extra bit captures the carry out of the accumulator for overflow.
    assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};

    beat_counter #(
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (start_accept),
        .len      (len),
        .dec      (beat),
        .last     (last),
        .zero_len (zero_len)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_len ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            acc_out  <= '0;
            overflow <= 1'b0;
        end else if (start_accept) begin
            acc      <= '0;
            acc_out  <= '0;
            overflow <= 1'b0;
        end else if (beat) begin
            acc <= sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
                overflow <= 1'b1;
            end
            // The final sum is published in the same edge the last beat lands.
            if (last) begin
                acc_out <= sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomized checks of product_accumulator against a queue-based
// reference sum, using a default-width instance and a 33-bit instance.
module tb_product_accumulator;

    localparam int PW = 32;
    localparam int CW = 8;
    localparam int AW = 40;
    localparam int OW = 33;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          in_valid;
    logic [PW-1:0] product;
    logic          out_ready;

    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic          overflow;
    logic [AW-1:0] acc_out;

    logic          o_in_ready;
    logic          o_out_valid;
    logic          o_busy;
    logic          o_overflow;
    logic [OW-1:0] o_acc_out;

    int n_tests;
    int n_fail;
    int n_acc;

    logic [PW-1:0] beats_q[$];

    product_accumulator #(
        .PROD_W (PW),
        .CNT_W  (CW),
        .ACC_W  (AW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .busy      (busy),
        .overflow  (overflow)
    );

    product_accumulator #(
        .PROD_W (PW),
        .CNT_W  (CW),
        .ACC_W  (OW)
    ) u_ovf (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (o_in_ready),
        .product   (product),
        .out_valid (o_out_valid),
        .out_ready (out_ready),
        .acc_out   (o_acc_out),
        .busy      (o_busy),
        .overflow  (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beats accepted by the default instance, counted where in_valid and
    // in_ready are both stable ahead of the accepting edge.
    initial n_acc = 0;
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            n_acc <= n_acc + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the run's result is the plain arithmetic total of all beats.
    function automatic logic [63:0] model_total();
        logic [63:0] t;
        t = '0;
        foreach (beats_q[i]) t += {32'd0, beats_q[i]};
        return t;
    endfunction

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic start_run(input logic [CW-1:0] l);
        start = 1'b1;
        len   = l;
        beats_q.delete();
        @(posedge clk); #1;
        start = 1'b0;
        len   = CW'($urandom);
    endtask

    task automatic feed(input logic [PW-1:0] p, input int gap_pct);
        int gaps;
        bit taken;
        gaps  = 0;
        taken = 1'b0;
        while (gaps < 8 && int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            product  = PW'($urandom);
            @(posedge clk); #1;
            gaps++;
        end
        in_valid = 1'b1;
        product  = p;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("feed_accept", {63'd0, taken}, 64'd1);
        beats_q.push_back(p);
    endtask

    task automatic check_result(input string tag);
        logic [63:0] t;
        t = model_total();
        @(negedge clk);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_acc"}, {24'd0, acc_out}, {24'd0, t[AW-1:0]});
        check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, |t[63:AW]});
        check({tag, "_o_acc"}, {31'd0, o_acc_out}, {31'd0, t[OW-1:0]});
        check({tag, "_o_ovf"}, {63'd0, o_overflow}, {63'd0, |t[63:OW]});
        @(posedge clk); #1;
    endtask

    task automatic release_result(input string tag, input int hold);
        logic [63:0] t;
        t = model_total();
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
            check({tag, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
            check({tag, "_hold_acc"}, {24'd0, acc_out}, {24'd0, t[AW-1:0]});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check({tag, "_rel_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_rel_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_rel_o_busy"}, {63'd0, o_busy}, 64'd0);
        check({tag, "_rel_acc"}, {24'd0, acc_out}, {24'd0, t[AW-1:0]});
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        int l;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        product   = '0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        check("rst_acc", {24'd0, acc_out}, 64'd0);
        check("rst_ready", {63'd0, in_ready}, 64'd0);
        check("rst_o_ready", {63'd0, o_in_ready}, 64'd0);
        @(posedge clk); #1;

        // Basic three-beat run on consecutive cycles
        start_run(8'd3);
        @(negedge clk);
        check("t1_busy", {63'd0, busy}, 64'd1);
        check("t1_ready", {63'd0, in_ready}, 64'd1);
        check("t1_valid_early", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        feed(32'h0000_0006, 0);
        feed(32'h0000_0014, 0);
        feed(32'hFFFE_0001, 0);
        check_result("t1");
        @(negedge clk);
        check("t1_const", {24'd0, acc_out}, 64'h00_00FF_FE00_1B);
        @(posedge clk); #1;

        // Backpressure in DONE while start and in_valid are pushed at it
        start    = 1'b1;
        len      = 8'd7;
        in_valid = 1'b1;
        product  = PW'($urandom);
        release_result("t4", 5);
        @(negedge clk);
        check("t4_still_idle", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;

        // Zero-length run
        start_run(8'd0);
        @(negedge clk);
        check("t2_valid", {63'd0, out_valid}, 64'd1);
        check("t2_acc", {24'd0, acc_out}, 64'd0);
        check("t2_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        release_result("t2", 0);

        // Full-length run with random in_valid gaps
        base = n_acc;
        start_run(8'd255);
        for (int i = 0; i < 255; i++) feed(32'hFFFE_0001, 30);
        in_valid = 1'b1;
        product  = PW'($urandom);
        check_result("t3");
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("t3_beats", 64'(n_acc - base), 64'd255);
        @(negedge clk);
        check("t3_const", {24'd0, acc_out}, 64'h00_FEFE_0200_FF);
        @(posedge clk); #1;
        release_result("t3", 1);

        // Reset in the middle of a run
        start_run(8'd4);
        feed(PW'($urandom), 0);
        feed(PW'($urandom), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        beats_q.delete();
        @(negedge clk);
        check("t5_rst_valid", {63'd0, out_valid}, 64'd0);
        check("t5_rst_busy", {63'd0, busy}, 64'd0);
        check("t5_rst_ready", {63'd0, in_ready}, 64'd0);
        check("t5_rst_acc", {24'd0, acc_out}, 64'd0);
        check("t5_rst_ovf", {63'd0, overflow}, 64'd0);
        check("t5_rst_o_ovf", {63'd0, o_overflow}, 64'd0);
        check("t5_rst_o_acc", {31'd0, o_acc_out}, 64'd0);
        @(posedge clk); #1;
        start_run(8'd1);
        feed(32'h0000_0007, 0);
        check_result("t5");
        @(negedge clk);
        check("t5_const", {24'd0, acc_out}, 64'd7);
        @(posedge clk); #1;
        release_result("t5", 0);

        // Overflow on the 33-bit instance, cleared by the next start
        start_run(8'd3);
        repeat (3) feed(32'hFFFE_0001, 0);
        check_result("t6");
        @(negedge clk);
        check("t6_o_ovf_const", {63'd0, o_overflow}, 64'd1);
        check("t6_o_acc_const", {31'd0, o_acc_out}, 64'h0_FFFA_0003);
        @(posedge clk); #1;
        release_result("t6", 2);
        start_run(8'd1);
        @(negedge clk);
        check("t6_ovf_cleared", {63'd0, o_overflow}, 64'd0);
        @(posedge clk); #1;
        feed(32'h0000_0001, 0);
        check_result("t6b");
        release_result("t6b", 0);

        // Randomized runs against the reference total
        for (int r = 0; r < 8; r++) begin
            l = int'($urandom_range(20, 1));
            start_run(CW'(l));
            for (int i = 0; i < l; i++) feed(PW'($urandom), 25);
            check_result("rnd");
            release_result("rnd", int'($urandom_range(3, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the unsigned 16x16 array multiplier's 32-bit product.
- Accumulates a programmed number of product beats into a wide accumulator (dot-product / MAC back end).
- Presents the sum on a valid/ready output.
- Sits between the combinational multiplier and the result sink; adds the sequencing and flow control the multiplier lacks.

Parameters:
- PROD_W, 32, width of incoming product (unsigned).
- CNT_W, 8, width of beat-count field; max terms per run = 2^CNT_W - 1.
- ACC_W, 40, accumulator width. Default gives PROD_W+CNT_W guard, so no overflow at defaults.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- len  input  CNT_W  number of product beats in the run; latched on accepted start.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- product  input  PROD_W  unsigned product from the multiplier.
- out_valid  output  1  acc_out holds a completed sum.
- out_ready  input  1  sink accepts the result.
- acc_out  output  ACC_W  accumulated sum.
- busy  output  1  state != IDLE.
- overflow  output  1  sticky; carry out of ACC_W seen during the current or last run.

Behaviour:
- Reset (rst=1 at a rising edge), dominant in every state:
  - state=IDLE; acc, remaining, acc_out all 0.
  - out_valid=0, busy=0, overflow=0.
  - A partial sum is discarded. Reset mid-run leaves no residue.
- States: IDLE, ACCUM, DONE.
- in_ready is combinational: in_ready = (state==ACCUM). A beat is accepted on an edge where in_valid and in_ready are both 1.
- IDLE:
  - On start=1: latch remaining=len, acc=0, overflow=0.
  - If len==0: go to DONE with acc_out=0 and out_valid=1 on the next cycle.
  - Otherwise go to ACCUM.
- ACCUM, on each accepted beat:
  - acc <= acc + zero-extend(product), modulo 2^ACC_W.
  - Carry out of bit ACC_W-1 sets overflow.
  - remaining decrements.
  - Beats with in_valid=0 stall with no state change.
- Last beat (remaining==1, beat accepted) at edge k:
  - acc_out = final sum, out_valid=1 visible in cycle k+1.
  - Latency from last beat to result: 1 cycle.
- DONE:
  - acc_out and out_valid stay stable until out_ready=1.
  - On out_valid & out_ready go to IDLE; out_valid=0 the following cycle. acc_out holds its value until the next start.
  - start asserted in DONE, including during the handshake cycle, is ignored; it must be re-presented in IDLE.
- start while busy is ignored. len changes outside IDLE have no effect.
- Arithmetic is unsigned throughout. overflow clears only on an accepted start or on rst.

Decomposition:
- Shared package mac_pkg:
  - state enum (IDLE, ACCUM, DONE).
  - default constants PROD_W=32, CNT_W=8, ACC_W=40.
- One natural sub-module, beat_counter: loadable CNT_W down-counter with a terminal (remaining==1) flag and a zero-length flag.
- The accumulator adder and FSM live in the top.

Test Plan:
1. Basic run: start, len=3; products 0x6, 0x14, 0xFFFE0001 on consecutive cycles -> acc_out=0x00FFFE001B, out_valid 1 cycle after third beat, overflow=0.
2. Zero length: start, len=0 -> next cycle state DONE, out_valid=1, acc_out=0. With out_ready=1 -> IDLE, busy=0 the cycle after.
3. Full length: len=255, all products 0xFFFE0001 with random in_valid gaps -> acc_out=0xFEFE0200FF, overflow=0, exactly 255 beats accepted.
4. Backpressure: after case 1, hold out_ready=0 for 5 cycles while driving in_valid=1 and start=1 -> in_ready=0 throughout, acc_out stable, start ignored. Release out_ready -> IDLE.
5. Reset mid-run: len=4, rst pulsed after 2 beats -> next cycle all outputs 0, state IDLE. Then start, len=1, product 0x7 -> acc_out=0x7.
6. Overflow (ACC_W=33): len=3, products 0xFFFE0001 x3 -> overflow=1, acc_out=0x0FFFA0003 (wrapped). A following start clears overflow.
